sha2_block_engine: RTL and testbench

//  Parametrised SHA-224/SHA-256 compression engine with multi-block chaining.
//  - Accepts pre-padded 512-bit blocks over a valid/ready handshake.
//  - Runs UNROLL rounds per clock.
//  - Chains the hash state across blocks of one message; returns the digest over a valid/ready handshake.
//  - Sits between the message padder/DMA front end and the digest sink.

---
 rtl/sha2_pkg.sv | 46 ++++
 rtl/sha2_round.sv | 16 +
 rtl/sha2_block_engine.sv | 92 +++++++++
 tb/tb_sha2_block_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// sha2_pkg: SHA-224/256 constants, round functions and engine types
package sha2_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_e;
  typedef struct packed {word_t a, b, c, d, e, f, g, h;} abcd_t;
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam abcd_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam abcd_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t Ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic word_t Maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic word_t SIG0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic word_t SIG1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic word_t sig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t sig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic abcd_t iv(logic mode224);
    return mode224 ? IV224 : IV256;
  endfunction
  function automatic abcd_t add_state(abcd_t x, abcd_t y);
    return '{x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d, x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h};
  endfunction
endpackage

// File: rtl/sha2_round.sv
// sha2_round: one combinational SHA-2 compression round
module sha2_round
  import sha2_pkg::*;
(
  input  abcd_t s_i,
  input  word_t w_i,
  input  word_t k_i,
  output abcd_t s_o
);
  word_t t1, t2;
  always_comb begin
    t1 = s_i.h + SIG1(s_i.e) + Ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
    t2 = SIG0(s_i.a) + Maj(s_i.a, s_i.b, s_i.c);
    s_o = '{t1 + t2, s_i.a, s_i.b, s_i.c, s_i.d + t1, s_i.e, s_i.f, s_i.g};
  end
endmodule

// File: rtl/sha2_block_engine.sv
// sha2_block_engine: SHA-224/256 block compression, UNROLL rounds per clock,
// hash state chained across the blocks of a message
module sha2_block_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [511:0] i_Block,
  input  logic         i_First,
  input  logic         i_Mode224,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [255:0] o_Digest
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad
    $error("UNROLL must be 1, 2, 4 or 8");
  end
  state_e       state_q;
  abcd_t        h_q, work_q, h_d, work_d;
  word_t        w_q [16];
  word_t        ext [16+UNROLL];
  logic [5:0]   cnt_q;
  logic         mode_q, ready_q, valid_q;
  logic [255:0] digest_q;
  // ext[16..] holds the UNROLL schedule words produced this clock; later ones feed on earlier ones
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int i = 0; i < UNROLL; i++) ext[16+i] = sig1(ext[14+i]) + ext[9+i] + sig0(ext[1+i]) + ext[i];
  end
  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    abcd_t s_in, s;
    if (i == 0) begin : g_head
      assign s_in = work_q;
    end else begin : g_tail
      assign s_in = g_rnd[i-1].s;
    end
    sha2_round u_round (.s_i(s_in), .w_i(ext[i]), .k_i(K[cnt_q + 6'(i)]), .s_o(s));
  end
  assign work_d = g_rnd[UNROLL-1].s;
  assign h_d = add_state(h_q, work_q);
  assign o_Ready = ready_q;
  assign o_Valid = valid_q;
  assign o_Digest = digest_q;
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      digest_q <= '0;
      h_q <= IV256;
      work_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      w_q <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: if (i_Valid) begin
          for (int i = 0; i < 16; i++) w_q[i] <= i_Block[511-32*i -: 32];
          work_q <= i_First ? iv(i_Mode224) : h_q;
          if (i_First) begin
            h_q <= iv(i_Mode224);
            mode_q <= i_Mode224;
          end
          cnt_q <= '0;
          ready_q <= 1'b0;
          state_q <= ROUND;
        end
        ROUND: begin
          work_q <= work_d;
          for (int i = 0; i < 16; i++) w_q[i] <= ext[i+UNROLL];
          cnt_q <= cnt_q + 6'(UNROLL);
          if (cnt_q == 6'(64 - UNROLL)) state_q <= FINAL;
        end
        FINAL: begin
          h_q <= h_d;
          digest_q <= mode_q ? {h_d[255:32], 32'h0} : h_d;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (i_Ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sha2_block_engine.sv
// tb_sha2_block_engine: directed known-answer bench with a digest scoreboard
module tb_sha2_block_engine;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] M1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2 = {448'h0, 32'h00000000, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  typedef struct {logic [255:0] d; bit c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] blk;
  logic first, m224;
  logic in_vld [4];
  logic in_rdy [4];
  logic rdy [4];
  logic ov [4];
  logic [255:0] dig [4];
  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha2_block_engine #(.UNROLL(1 << g)) u_dut (
      .i_Clk(clk), .i_Rst(rst_n), .i_Valid(in_vld[g]), .o_Ready(rdy[g]),
      .i_Block(blk), .i_First(first), .i_Mode224(m224),
      .o_Valid(ov[g]), .i_Ready(in_rdy[g]), .o_Digest(dig[g]));
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [511:0] b, input logic f, input logic m, input logic [255:0] d, input bit c);
    int n = 0;
    blk = b;
    first = f;
    m224 = m;
    in_vld[0] = 1'b1;
    while (!rdy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", rdy[0], 1);
    @(negedge clk);
    in_vld[0] = 1'b0;
    exp_q.push_back('{d, c});
  endtask
  task automatic wait_check(input string tag);
    int n = 0;
    exp_t e;
    while (!ov[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, ov[0], 1);
    chk({tag, "_sb"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.c) chk(tag, dig[0], e.d);
    end
  endtask
  task automatic ack(input string tag, input int dly);
    repeat (dly) @(negedge clk);
    in_rdy[0] = 1'b1;
    @(negedge clk);
    in_rdy[0] = 1'b0;
    chk({tag, "_ready_after"}, rdy[0], 1);
    chk({tag, "_valid_drop"}, ov[0], 0);
  endtask
  initial begin
    int lat [4];
    for (int g = 0; g < 4; g++) begin
      in_vld[g] = 1'b0;
      in_rdy[g] = 1'b0;
    end
    blk = '0;
    first = 1'b0;
    m224 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy[0], 1);
    chk("rst_valid", ov[0], 0);
    chk("rst_digest", dig[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(ABC, 1, 0, D_ABC, 1);
    wait_check("abc256");
    ack("abc256", 0);
    send(ABC, 1, 1, D_ABC224, 1);
    wait_check("abc224");
    ack("abc224", 0);
    send(M1, 1, 0, '0, 0);
    wait_check("two_mid");
    ack("two_mid", 5);
    send(M2, 0, 0, D_TWO, 1);
    wait_check("two_final");
    ack("two_final", 0);
    blk = EMPTY;
    first = 1'b1;
    m224 = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk("empty_idle", rdy[g], 1);
      in_vld[g] = 1'b1;
      lat[g] = 0;
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) in_vld[g] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (ov[g] && lat[g] == 0) lat[g] = k;
    end
    for (int g = 0; g < 4; g++) begin
      chk("empty_latency", 256'(lat[g]), 256'(64 / (1 << g) + 1));
      chk("empty_digest", dig[g], D_EMPTY);
      in_rdy[g] = 1'b1;
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) in_rdy[g] = 1'b0;
    send(ABC, 1, 0, D_ABC, 1);
    wait_check("hold_abc");
    for (int k = 0; k < 20; k++) begin
      in_vld[0] = k[0];
      blk = EMPTY;
      first = 1'b1;
      @(negedge clk);
      chk("hold_digest", dig[0], D_ABC);
      chk("hold_ready", rdy[0], 0);
      chk("hold_valid", ov[0], 1);
    end
    in_vld[0] = 1'b1;
    in_rdy[0] = 1'b1;
    @(negedge clk);
    in_rdy[0] = 1'b0;
    chk("hold_no_accept", rdy[0], 1);
    chk("hold_released", ov[0], 0);
    in_vld[0] = 1'b0;
    repeat (70) @(negedge clk);
    chk("no_capture_valid", ov[0], 0);
    chk("no_capture_ready", rdy[0], 1);
    send(ABC, 1, 0, D_ABC, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", ov[0], 0);
    chk("midrst_ready", rdy[0], 1);
    chk("midrst_digest", dig[0], 0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    send(ABC, 0, 1, D_ABC, 1);
    wait_check("rst_chain_iv");
    ack("rst_chain_iv", 0);
    send(ABC, 1, 0, D_ABC, 1);
    wait_check("rst_rerun");
    ack("rst_rerun", 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
